// File: rtl/nv_clk_gate_pkg.sv
// Shared definitions for the clock-gate controller: state encoding,
// counter widths and saturating counter helpers.
package nv_clk_gate_pkg;

  typedef enum logic [1:0] {
    CG_ON        = 2'd0,
    CG_IDLE_WAIT = 2'd1,
    CG_OFF       = 2'd2,
    CG_WAKE      = 2'd3
  } cg_state_e;

  localparam int IDLE_CNT_W = 8;
  localparam int WAKE_CNT_W = 4;

  // Saturating increment for the idle counter; holds at all-ones.
  function automatic logic [IDLE_CNT_W-1:0] idle_sat_inc(input logic [IDLE_CNT_W-1:0] v);
    logic [IDLE_CNT_W-1:0] res;
    if (v == {IDLE_CNT_W{1'b1}}) begin
      res = v;
    end else begin
      res = v + {{(IDLE_CNT_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

  // Saturating increment for the wake counter; holds at all-ones.
  function automatic logic [WAKE_CNT_W-1:0] wake_sat_inc(input logic [WAKE_CNT_W-1:0] v);
    logic [WAKE_CNT_W-1:0] res;
    if (v == {WAKE_CNT_W{1'b1}}) begin
      res = v;
    end else begin
      res = v + {{(WAKE_CNT_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

endpackage

// File: rtl/nv_clk_gate_ctrl_power.sv
// Latch-based clock-gate cell. The enable is captured while clk is low so
// the gated clock never carries a truncated high pulse. Reset opens the gate.
module NV_CLK_gate_power (
  input  logic clk,
  input  logic clk_en,
  input  logic reset_,
  output logic clk_gated
);

  logic en_lat_r;

  // Transparent-low enable latch; forced open while reset is active.
  always_latch begin
    if (!reset_) begin
      en_lat_r <= 1'b1;
    end else if (!clk) begin
      en_lat_r <= clk_en;
    end
  end

  assign clk_gated = clk & en_lat_r;

endmodule

// File: rtl/nv_clk_gate_ctrl.sv
// Clock-gate controller: turns the gated domain off after IDLE_CYC quiet
// cycles, wakes it on any request and grants requesters only once the
// gated clock has been running for WAKE_CYC cycles.
module nv_clk_gate_ctrl
  import nv_clk_gate_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int IDLE_CYC = 16,
  parameter int WAKE_CYC = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            force_on,
  output logic [NREQ-1:0] ack,
  output logic            clk_en,
  output logic            clk_gated,
  output logic [1:0]      cg_state,
  output logic            gate_off_pulse
);

  localparam logic [IDLE_CNT_W-1:0] IDLE_TERM = IDLE_CNT_W'(IDLE_CYC - 1);
  localparam logic [WAKE_CNT_W-1:0] WAKE_TERM = WAKE_CNT_W'(WAKE_CYC - 1);

  cg_state_e             state_r;
  cg_state_e             state_nxt_s;
  logic [IDLE_CNT_W-1:0] idle_cnt_r;
  logic [IDLE_CNT_W-1:0] idle_cnt_nxt_s;
  logic [WAKE_CNT_W-1:0] wake_cnt_r;
  logic [WAKE_CNT_W-1:0] wake_cnt_nxt_s;
  logic                  any_req_s;
  logic [NREQ-1:0]       ack_nxt_s;
  logic                  clk_en_nxt_s;
  logic                  gate_off_nxt_s;
  logic [NREQ-1:0]       ack_r;
  logic                  clk_en_r;
  logic                  gate_off_pulse_r;
  logic                  reset_n_s;

  assign any_req_s = (|req) | force_on;

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= CG_ON;
      idle_cnt_r <= {IDLE_CNT_W{1'b0}};
      wake_cnt_r <= {WAKE_CNT_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      idle_cnt_r <= idle_cnt_nxt_s;
      wake_cnt_r <= wake_cnt_nxt_s;
    end
  end

  // Next-state and counter update; a request always beats the idle terminal count.
  always_comb begin
    state_nxt_s    = state_r;
    idle_cnt_nxt_s = {IDLE_CNT_W{1'b0}};
    wake_cnt_nxt_s = {WAKE_CNT_W{1'b0}};
    case (state_r)
      CG_ON: begin
        if (!any_req_s) begin
          state_nxt_s = CG_IDLE_WAIT;
        end else begin
          state_nxt_s = CG_ON;
        end
      end
      CG_IDLE_WAIT: begin
        if (any_req_s) begin
          state_nxt_s = CG_ON;
        end else if (idle_cnt_r == IDLE_TERM) begin
          state_nxt_s = CG_OFF;
        end else begin
          state_nxt_s    = CG_IDLE_WAIT;
          idle_cnt_nxt_s = idle_sat_inc(idle_cnt_r);
        end
      end
      CG_OFF: begin
        if (any_req_s) begin
          state_nxt_s = CG_WAKE;
        end else begin
          state_nxt_s = CG_OFF;
        end
      end
      CG_WAKE: begin
        // Once started, a wake always runs to completion.
        if (wake_cnt_r == WAKE_TERM) begin
          state_nxt_s = CG_ON;
        end else begin
          state_nxt_s    = CG_WAKE;
          wake_cnt_nxt_s = wake_sat_inc(wake_cnt_r);
        end
      end
      default: begin
        state_nxt_s = CG_ON;
      end
    endcase
  end

  // Next values of the registered outputs, derived from the next state.
  always_comb begin
    ack_nxt_s      = {NREQ{1'b0}};
    clk_en_nxt_s   = 1'b1;
    gate_off_nxt_s = 1'b0;
    if (state_nxt_s == CG_ON) begin
      ack_nxt_s = req;
    end else begin
      ack_nxt_s = {NREQ{1'b0}};
    end
    if (state_nxt_s == CG_OFF) begin
      clk_en_nxt_s   = 1'b0;
      gate_off_nxt_s = (state_r != CG_OFF);
    end else begin
      clk_en_nxt_s   = 1'b1;
      gate_off_nxt_s = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_r            <= {NREQ{1'b0}};
      clk_en_r         <= 1'b1;
      gate_off_pulse_r <= 1'b0;
    end else begin
      ack_r            <= ack_nxt_s;
      clk_en_r         <= clk_en_nxt_s;
      gate_off_pulse_r <= gate_off_nxt_s;
    end
  end

  assign ack            = ack_r;
  assign clk_en         = clk_en_r;
  assign gate_off_pulse = gate_off_pulse_r;
  assign cg_state       = state_r;
  assign reset_n_s      = ~reset;

  NV_CLK_gate_power u_cg (
    .clk       (clk),
    .clk_en    (clk_en_r),
    .reset_    (reset_n_s),
    .clk_gated (clk_gated)
  );

endmodule

// File: tb/tb_nv_clk_gate_ctrl.sv
// Self-checking bench for nv_clk_gate_ctrl with a quiet-run / wake-countdown
// reference model, directed scenarios and randomized request runs.
module tb_nv_clk_gate_ctrl;

  localparam int NREQ     = 4;
  localparam int IDLE_CYC = 16;
  localparam int WAKE_CYC = 2;

  logic            clk;
  logic            reset;
  logic [NREQ-1:0] req;
  logic            force_on;
  logic [NREQ-1:0] ack;
  logic            clk_en;
  logic            clk_gated;
  logic [1:0]      cg_state;
  logic            gate_off_pulse;

  nv_clk_gate_ctrl #(
    .NREQ     (NREQ),
    .IDLE_CYC (IDLE_CYC),
    .WAKE_CYC (WAKE_CYC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .force_on       (force_on),
    .ack            (ack),
    .clk_en         (clk_en),
    .clk_gated      (clk_gated),
    .cg_state       (cg_state),
    .gate_off_pulse (gate_off_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the domain is either off, counting down a wake, or on
  // with a running count of consecutive quiet cycles.
  bit              m_off;
  int              m_wake_left;
  int              m_quiet;
  logic [1:0]      e_state;
  logic            e_en;
  logic            e_prev_en;
  logic [NREQ-1:0] e_ack;
  logic            e_pulse;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_off       = 1'b0;
    m_wake_left = 0;
    m_quiet     = 0;
    e_state     = 2'd0;
    e_en        = 1'b1;
    e_prev_en   = 1'b1;
    e_ack       = '0;
    e_pulse     = 1'b0;
  endtask

  task automatic model_step(input logic [NREQ-1:0] r, input logic f);
    bit busy;
    bit on;
    busy      = (r != 0) || f;
    e_pulse   = 1'b0;
    e_prev_en = e_en;
    if (m_off) begin
      if (busy) begin
        m_off       = 1'b0;
        m_wake_left = WAKE_CYC;
      end
    end else if (m_wake_left > 0) begin
      m_wake_left--;
    end else begin
      if (busy) m_quiet = 0;
      else m_quiet++;
      if (m_quiet == IDLE_CYC + 1) begin
        m_off   = 1'b1;
        m_quiet = 0;
        e_pulse = 1'b1;
      end
    end
    on      = !m_off && (m_wake_left == 0) && (m_quiet == 0);
    e_en    = !m_off;
    e_state = m_off ? 2'd2 : (m_wake_left > 0) ? 2'd3 : (m_quiet > 0) ? 2'd1 : 2'd0;
    e_ack   = on ? r : '0;
  endtask

  task automatic check_all();
    check_val("cg_state", cg_state, e_state);
    check_val("clk_en", clk_en, e_en);
    check_val("ack", ack, e_ack);
    check_val("gate_off_pulse", gate_off_pulse, e_pulse);
    // Sampled in the high phase: the gate passes the enable latched before this edge.
    check_val("clk_gated", clk_gated, e_prev_en);
  endtask

  task automatic step(input logic [NREQ-1:0] r, input logic f);
    req      = r;
    force_on = f;
    @(posedge clk);
    model_step(r, f);
    #1;
    check_all();
  endtask

  initial begin
    int len;
    int kind;
    logic [NREQ-1:0] r;
    logic f;

    reset    = 1'b1;
    req      = '0;
    force_on = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;

    // Idle after reset: OFF on cycle 17, single gate-off pulse, gated clock flat.
    repeat (22) step('0, 1'b0);

    // Wake from OFF with one requester.
    repeat (4) step(4'b0010, 1'b0);

    // Request drop then return inside IDLE_WAIT.
    repeat (10) step('0, 1'b0);
    repeat (3) step(4'b0001, 1'b0);

    // Request arrives exactly at the terminal idle cycle.
    repeat (16) step('0, 1'b0);
    repeat (2) step(4'b0100, 1'b0);

    // Software override keeps the clock on without granting.
    repeat (100) step('0, 1'b1);
    repeat (17) step('0, 1'b0);
    repeat (3) step('0, 1'b0);

    // Override also wakes from OFF without any grant.
    repeat (5) step('0, 1'b1);
    repeat (18) step('0, 1'b0);

    // Reset asserted in the middle of a wake.
    step(4'b0001, 1'b0);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) step(4'b1001, 1'b0);

    // Randomized runs of quiet, requests and overrides.
    for (int k = 0; k < 120; k++) begin
      len  = $urandom_range(1, 24);
      kind = $urandom_range(0, 3);
      for (int c = 0; c < len; c++) begin
        if (kind < 2) begin
          r = '0;
          f = 1'b0;
        end else begin
          r = NREQ'($urandom_range(0, 15));
          f = (kind == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        step(r, f);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nv_clk_gate_ctrl.md
NV_CLK_GATE_CTRL -- requirements
Module: nv_clk_gate_ctrl

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, range 1..8.
REQ-002 Parameter IDLE_CYC, default 16: idle cycles before gating, range 1..255.
REQ-003 Parameter WAKE_CYC, default 2: cycles clk_en is held before ack, range 1..15.
REQ-004 Port clk  input  1  free-running core clock; one clock domain.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port req  input  NREQ  per-requester level request/busy for the gated domain.
REQ-007 Port force_on  input  1  software override that keeps the clock on.
REQ-008 Port ack  output  NREQ  per-requester grant; the gated clock is running and stable.
REQ-009 Port clk_en  output  1  registered enable to the clock-gate cell.
REQ-010 Port clk_gated  output  1  gated clock.
REQ-011 Port cg_state  output  2  current state: ON=0, IDLE_WAIT=1, OFF=2, WAKE=3.
REQ-012 Port gate_off_pulse  output  1  one-cycle pulse on every entry to OFF.

Function
REQ-013 The FSM SHALL have exactly four states: ON, IDLE_WAIT, OFF, WAKE; any_req = |req | force_on.
REQ-014 ON: any_req=0 SHALL go to IDLE_WAIT with idle_cnt=0; otherwise stay ON.
REQ-015 IDLE_WAIT: any_req=1 SHALL return to ON next cycle with idle_cnt cleared; else idle_cnt increments; at idle_cnt==IDLE_CYC-1 with any_req=0 SHALL go to OFF.
REQ-016 OFF: any_req=1 SHALL go to WAKE with wake_cnt=0; otherwise stay OFF.
REQ-017 WAKE: wake_cnt increments each cycle regardless of req; at wake_cnt==WAKE_CYC-1 SHALL go to ON; a request drop in WAKE SHALL NOT abort the wake.
REQ-018 clk_en SHALL be registered as (next_state != OFF), so it changes only on clk rising edges and is glitch-free.
REQ-019 ack[i] SHALL be registered as (next_state==ON) & req[i]; ack SHALL never be 1 while cg_state is OFF or WAKE.
REQ-020 Latency: in ON, req[i] rising at t gives ack[i] at t+1; from OFF, req rising at t gives clk_en=1 at t+1 and ack at t+1+WAKE_CYC.
REQ-021 Gate-off latency: last req cycle t-1, with req low from t onward, gives cg_state=OFF and clk_en=0 at t+1+IDLE_CYC.
REQ-022 When req rises in the same cycle that idle_cnt reaches terminal, the request wins and the FSM SHALL go to ON.
REQ-023 force_on=1 SHALL behave as a request in all states but SHALL NOT assert any ack bit.
REQ-024 idle_cnt SHALL be 8 bits and wake_cnt 4 bits, saturating; neither counter wraps.
REQ-025 gate_off_pulse SHALL be registered and high for exactly the first cycle of OFF.

Reset
REQ-026 Reset SHALL force cg_state=ON, clk_en=1, ack=0, gate_off_pulse=0, idle_cnt=0, wake_cnt=0, in any state including mid-WAKE or mid-IDLE_WAIT.
REQ-027 After reset deasserts, the first transition SHALL follow REQ-014 on the first clk edge.

Structure
REQ-028 Package nv_clk_gate_pkg SHALL hold the state enum encoding and the counter width constants.
REQ-029 The block SHALL instantiate one NV_CLK_gate_power, with clk=clk, clk_en=clk_en, reset_=~reset, driving clk_gated; all other logic SHALL be inline.

Verification
REQ-030 Reset then idle, defaults: OFF entered on cycle 17 after reset release; gate_off_pulse high once; clk_gated flat.
REQ-031 From OFF, req=4'b0010 at t: clk_en=1 at t+1; cg_state WAKE at t+1 and t+2; ON with ack=4'b0010 at t+3.
REQ-032 req drops at t; req[0] rises at t+10 in IDLE_WAIT: ON at t+11, ack[0] at t+11, clk_en never drops.
REQ-033 req rises exactly at the terminal idle cycle (t+16): no OFF entry; gate_off_pulse stays 0.
REQ-034 force_on=1 with req=0 for 100 cycles: state stays ON, ack=0; force_on=0 gives OFF 17 cycles later.
REQ-035 Reset asserted mid-WAKE: clk_en=1, cg_state=ON, ack=0 immediately (asynchronous); no X on clk_gated after reset.
